// File: rtl/roc_seq_pkg.sv
// Shared definitions for the ring-oscillator challenge/response sequencer.
// Holds the FSM state encoding, the challenge generator selectors and their reset values,
// and the LFSR feedback helper used by the challenge stepper.
package roc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_MEAS   = 3'd2,
    ST_CAPT   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  localparam int CG_CNT  = 1;
  localparam int CG_LFSR = 2;

  localparam logic [15:0] CHL_RST_CNT  = 16'h0000;
  localparam logic [15:0] CHL_RST_LFSR = 16'h0001;
  // Feedback taps at bits 5,3,2,0
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;

  // Right shift with the parity of the tapped bits entering at the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

  function automatic logic [15:0] chl_rst_val(input int cg_type);
    return (cg_type == CG_LFSR) ? CHL_RST_LFSR : CHL_RST_CNT;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/roc_chl_step.sv
// 16-bit stepped challenge generator: a wrapping counter or a right-shift LFSR.
// Latency: the new challenge is visible the cycle after step_i.
// No backpressure; the value is held whenever step_i is low.
module roc_chl_step
  import roc_seq_pkg::*;
#(
  parameter int CG_TYPE = CG_CNT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [15:0] chl_o
);

  logic [15:0] chl_q;
  logic [15:0] chl_d;

  generate
    if (CG_TYPE == CG_LFSR) begin : g_lfsr
      // LFSR successor of the current challenge
      always_comb chl_d = lfsr_next(chl_q);
    end else begin : g_cnt
      // Counter successor, wraps FFFF -> 0000
      always_comb chl_d = chl_q + 16'd1;
    end
  endgenerate

  // Challenge register, advances only when stepped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chl_q <= chl_rst_val(CG_TYPE);
    end else if (step_i) begin
      chl_q <= chl_d;
    end
  end

  assign chl_o = chl_q;

endmodule

// File: rtl/roc_seq.sv
// Sequencer for the RO challenge/response TRNG: settle, measure, capture one bit per challenge.
// Latency: W*(SETTLE_CYC+MEAS_CYC+1+response delay) cycles per word.
// Backpressure: a finished word is held on out_data with the RO bank idle until out_ready.
module roc_seq
  import roc_seq_pkg::*;
#(
  parameter int CG_TYPE    = CG_CNT,
  parameter int SETTLE_CYC = 4,
  parameter int MEAS_CYC   = 64,
  parameter int TMO_CYC    = 255,
  parameter int W          = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr_err,
  output logic [7:0]   cnf1,
  output logic [7:0]   cnf2,
  output logic         ro_en,
  input  logic         resp_bit,
  input  logic         resp_vld,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         tmo_err
);

  localparam int CW = $clog2(max3(SETTLE_CYC, MEAS_CYC, TMO_CYC) + 1);
  localparam int BW = $clog2(W + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] MEAS_LAST   = CW'(MEAS_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TMO_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(W - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  win_q, win_d;
  logic [BW-1:0]  bits_q, bits_d;
  logic [W-1:0]   word_q, word_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           ro_en_q, ro_en_d;
  logic           tmo_err_q, tmo_err_d;
  logic [15:0]    chl;

  logic           in_run;
  logic           abort;
  logic           accept;
  logic           timeout;
  logic           handshake;
  logic           word_done;
  logic [W-1:0]   word_shift;

  assign in_run     = (state_q == ST_SETTLE) || (state_q == ST_MEAS) || (state_q == ST_CAPT);
  assign abort      = in_run && !en;
  assign accept     = (state_q == ST_CAPT) && en && resp_vld;
  assign timeout    = (state_q == ST_CAPT) && en && !resp_vld && (win_q == TMO_LAST);
  assign handshake  = (state_q == ST_OUT) && out_valid_q && out_ready;
  assign word_done  = accept && (bits_q == BIT_LAST);
  assign word_shift = {word_q[W-2:0], resp_bit};

  roc_chl_step #(
    .CG_TYPE (CG_TYPE)
  ) u_chl (
    .clk_i  (clk),
    .rst_i  (reset),
    .step_i (accept | timeout),
    .chl_o  (chl)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: run enable dropping wins over window progress in the run states
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en) state_d = ST_SETTLE;
      ST_SETTLE: if (!en) state_d = ST_IDLE;
                 else if (win_q == SETTLE_LAST) state_d = ST_MEAS;
      ST_MEAS:   if (!en) state_d = ST_IDLE;
                 else if (win_q == MEAS_LAST) state_d = ST_CAPT;
      ST_CAPT:   if (!en) state_d = ST_IDLE;
                 else if (word_done) state_d = ST_OUT;
                 else if (accept || timeout) state_d = ST_SETTLE;
      ST_OUT:    if (handshake) state_d = en ? ST_SETTLE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values derived from the current and next state
  always_comb begin
    // Window counter restarts on every state change and idles outside timed states
    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_OUT)) begin
      win_d = '0;
    end else begin
      win_d = win_q + CW'(1);
    end

    // Registered so ro_en rises and falls on the same edge as entering/leaving MEAS
    ro_en_d = (state_d == ST_MEAS);

    bits_d = bits_q;
    word_d = word_q;
    if (abort || handshake) begin
      bits_d = '0;
      word_d = '0;
    end else if (accept) begin
      bits_d = bits_q + BW'(1);
      word_d = word_shift;
    end

    out_data_d  = word_done ? word_shift : out_data_q;
    out_valid_d = word_done ? 1'b1 : (handshake ? 1'b0 : out_valid_q);

    // A timeout in the same cycle as clr_err leaves the flag set
    tmo_err_d = timeout ? 1'b1 : (clr_err ? 1'b0 : tmo_err_q);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q       <= '0;
      bits_q      <= '0;
      word_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ro_en_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      win_q       <= win_d;
      bits_q      <= bits_d;
      word_q      <= word_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ro_en_q     <= ro_en_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign cnf1      = chl[7:0];
  assign cnf2      = chl[15:8];
  assign ro_en     = ro_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_roc_seq.sv
// Bench for roc_seq: counter and LFSR instances run in lockstep on shared stimulus.
// The bench plays the RO bank and the consumer, tracking challenge, word and error flag.
// Random response delays, timeouts, enable drops, consumer stalls and an async reset.
module tb_roc_seq;

  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int MEAS   = 4;
  localparam int TMO    = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         clr_err;
  logic         resp_bit;
  logic         resp_vld;
  logic         out_ready;

  logic [7:0]   c_cnf1, c_cnf2, l_cnf1, l_cnf2;
  logic         c_ro_en, l_ro_en, c_ov, l_ov, c_busy, l_busy, c_tmo, l_tmo;
  logic [W-1:0] c_od, l_od;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [15:0]  m_chl_c;
  logic [15:0]  m_chl_l;
  logic [W-1:0] m_word;
  int           m_bits;
  logic         m_tmo;

  always #5 clk = ~clk;

  roc_seq #(.CG_TYPE(1), .SETTLE_CYC(SETTLE), .MEAS_CYC(MEAS), .TMO_CYC(TMO), .W(W)) u_cnt (
    .clk(clk), .reset(reset), .en(en), .clr_err(clr_err),
    .cnf1(c_cnf1), .cnf2(c_cnf2), .ro_en(c_ro_en),
    .resp_bit(resp_bit), .resp_vld(resp_vld),
    .out_data(c_od), .out_valid(c_ov), .out_ready(out_ready),
    .busy(c_busy), .tmo_err(c_tmo)
  );

  roc_seq #(.CG_TYPE(2), .SETTLE_CYC(SETTLE), .MEAS_CYC(MEAS), .TMO_CYC(TMO), .W(W)) u_lfsr (
    .clk(clk), .reset(reset), .en(en), .clr_err(clr_err),
    .cnf1(l_cnf1), .cnf2(l_cnf2), .ro_en(l_ro_en),
    .resp_bit(resp_bit), .resp_vld(resp_vld),
    .out_data(l_od), .out_valid(l_ov), .out_ready(out_ready),
    .busy(l_busy), .tmo_err(l_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] cnt_succ(input logic [15:0] v);
    return v + 16'd1;
  endfunction

  // New MSB is chl[5]^chl[3]^chl[2]^chl[0], everything else shifts right
  function automatic logic [15:0] lfsr_succ(input logic [15:0] v);
    logic fb;
    fb = v[5] ^ v[3] ^ v[2] ^ v[0];
    return {fb, v[15:1]};
  endfunction

  task automatic model_step_chl();
    m_chl_c = cnt_succ(m_chl_c);
    m_chl_l = lfsr_succ(m_chl_l);
  endtask

  task automatic model_reset();
    m_chl_c = 16'h0000;
    m_chl_l = 16'h0001;
    m_word  = '0;
    m_bits  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_chl(input string tag);
    chk({tag, "_chl_cnt"},  32'({c_cnf2, c_cnf1}), 32'(m_chl_c));
    chk({tag, "_chl_lfsr"}, 32'({l_cnf2, l_cnf1}), 32'(m_chl_l));
  endtask

  task automatic chk_ctl(input string tag, input logic e_ro, input logic e_busy, input logic e_ov);
    chk({tag, "_ro_en"}, 32'({c_ro_en, l_ro_en}), 32'({e_ro, e_ro}));
    chk({tag, "_busy"},  32'({c_busy, l_busy}),   32'({e_busy, e_busy}));
    chk({tag, "_oval"},  32'({c_ov, l_ov}),       32'({e_ov, e_ov}));
  endtask

  // Inputs that the DUT must ignore outside CAPT/OUT
  task automatic noise();
    resp_vld  = 1'($urandom % 2);
    resp_bit  = 1'($urandom % 2);
    out_ready = 1'($urandom % 2);
  endtask

  // One challenge, entered at the negedge of the first SETTLE cycle.
  // delay<0 means no response (timeout); abort_at>=0 drops en in that MEAS cycle.
  task automatic do_bit(input int delay, input logic b, input int abort_at, input logic clr);
    for (int i = 0; i < SETTLE; i++) begin
      chk_ctl("settle", 1'b0, 1'b1, 1'b0);
      chk_chl("settle");
      noise();
      clr_err = (i == 0) && clr;
      step();
      clr_err = 1'b0;
      if (i == 0 && clr) m_tmo = 1'b0;
    end
    for (int i = 0; i < MEAS; i++) begin
      chk_ctl("meas", 1'b1, 1'b1, 1'b0);
      if (i == 0) chk("meas_tmo", 32'({c_tmo, l_tmo}), 32'({m_tmo, m_tmo}));
      noise();
      if (i == abort_at) begin
        en = 1'b0;
        step();
        chk_ctl("abort", 1'b0, 1'b0, 1'b0);
        chk_chl("abort");
        m_bits = 0;
        m_word = '0;
        en = 1'b1;
        resp_vld = 1'b0;
        step();
        return;
      end
      step();
    end
    chk_ctl("capt", 1'b0, 1'b1, 1'b0);
    resp_vld  = 1'b0;
    out_ready = 1'($urandom % 2);
    if (delay < 0) begin
      for (int i = 0; i < TMO; i++) begin
        if (i == TMO - 1) begin
          chk_ctl("tmo_last", 1'b0, 1'b1, 1'b0);
          chk("tmo_early", 32'({c_tmo, l_tmo}), 32'({m_tmo, m_tmo}));
          clr_err = 1'($urandom % 2);
        end
        step();
        clr_err = 1'b0;
      end
      m_tmo = 1'b1;
      model_step_chl();
    end else begin
      for (int i = 0; i < delay; i++) step();
      resp_vld = 1'b1;
      resp_bit = b;
      step();
      resp_vld = 1'b0;
      m_word = {m_word[W-2:0], b};
      m_bits++;
      model_step_chl();
    end
    chk("post_tmo", 32'({c_tmo, l_tmo}), 32'({m_tmo, m_tmo}));
  endtask

  // Entered at OUT cycle 0; stalls the consumer, optionally dropping en meanwhile
  task automatic do_out(input int stall, input logic drop_en);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk_ctl("stall", 1'b0, 1'b1, 1'b1);
      chk("stall_data_cnt",  32'(c_od), 32'(m_word));
      chk("stall_data_lfsr", 32'(l_od), 32'(m_word));
      chk_chl("stall");
      out_ready = 1'b0;
      resp_vld  = 1'($urandom % 2);
      resp_bit  = 1'($urandom % 2);
      step();
    end
    chk_ctl("out", 1'b0, 1'b1, 1'b1);
    chk("out_data_cnt",  32'(c_od), 32'(m_word));
    chk("out_data_lfsr", 32'(l_od), 32'(m_word));
    out_ready = 1'b1;
    resp_vld  = 1'b0;
    step();
    out_ready = 1'b0;
    m_bits = 0;
    m_word = '0;
    chk_ctl("after_hs", 1'b0, en, 1'b0);
    chk_chl("after_hs");
    if (!en) begin
      en = 1'b1;
      step();
    end
  endtask

  task automatic rand_word();
    int   d;
    int   ab;
    while (m_bits < W) begin
      d  = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, TMO - 1));
      ab = ($urandom % 12 == 0) ? int'($urandom_range(0, MEAS - 1)) : -1;
      do_bit(d, 1'($urandom % 2), ab, ($urandom % 4) == 0);
    end
    do_out(int'($urandom_range(0, 6)), ($urandom % 3) == 0);
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b1; en = 1'b0; clr_err = 1'b0;
    resp_bit = 1'b0; resp_vld = 1'b0; out_ready = 1'b0;
    model_reset();

    @(negedge clk);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_data", 32'({c_od, l_od}), 32'(0));
    chk("rst_tmo", 32'({c_tmo, l_tmo}), 32'(0));
    chk_chl("rst");
    reset = 1'b0;
    step();
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step();

    // Directed word: bits 1,0,1,1,0,0,1,0 each answered in the first CAPT cycle
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) do_bit(0, pat[i], -1, 1'b0);
    chk("word_b2", 32'(c_od), 32'(8'hB2));
    do_out(0, 1'b0);

    // Second word with a 20-cycle consumer stall
    while (m_bits < W) do_bit(int'($urandom_range(0, TMO - 1)), 1'($urandom % 2), -1, 1'b0);
    do_out(20, 1'b0);

    // Timeout, then a clr_err pulse on the next challenge
    do_bit(-1, 1'b0, -1, 1'b0);
    do_bit(2, 1'b1, -1, 1'b1);

    for (int n = 0; n < 20; n++) rand_word();

    // Asynchronous reset in the middle of MEAS
    for (int i = 0; i < SETTLE + 1; i++) begin
      noise();
      step();
    end
    resp_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_ctl("amid_rst", 1'b0, 1'b0, 1'b0);
    chk("amid_rst_data", 32'({c_od, l_od}), 32'(0));
    chk("amid_rst_tmo", 32'({c_tmo, l_tmo}), 32'(0));
    model_reset();
    chk_chl("amid_rst");
    #1 reset = 1'b0;
    @(negedge clk);
    rand_word();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/roc_seq.md
Name: roc_seq

Overview:
Sequencer for the ring-oscillator challenge/response TRNG path. It owns a stepped challenge register (counter or LFSR) that drives cnf1/cnf2 into the RO bank. It enforces settle and measurement windows and collects one response bit per challenge. Bits are packed into W-bit words and delivered over a valid/ready interface to the TRNG post-processing/FIFO.

Parameters:
CG_TYPE, 1, challenge generator type: Counter(1), LFSR(2)
SETTLE_CYC, 4, cycles cnf1/cnf2 held stable with ro_en low before measurement (>=1)
MEAS_CYC, 64, cycles ro_en held high per challenge (>=1)
TMO_CYC, 255, max cycles waiting for resp_vld after measurement (>=1)
W, 32, output word width (>=2)

Ports:
clk  input  1  clock; all logic on posedge clk
reset  input  1  asynchronous, active-high reset
en  input  1  run enable (level)
clr_err  input  1  clears tmo_err (one-cycle pulse)
cnf1  output  8  challenge low byte to RO bank
cnf2  output  8  challenge high byte to RO bank
ro_en  output  1  RO bank measurement enable
resp_bit  input  1  response bit from RO bank
resp_vld  input  1  resp_bit valid strobe
out_data  output  W  assembled random word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accept
busy  output  1  high in any state other than IDLE
tmo_err  output  1  sticky response-timeout flag

Behaviour:
- Reset (async, all registers): state IDLE; ro_en=0, out_valid=0, out_data=0, busy=0, tmo_err=0, bit count=0. Challenge = 16'h0000 (counter) or 16'h0001 (LFSR). cnf1=chl[7:0], cnf2=chl[15:8].
- Challenge step: counter chl<=chl+1, wraps FFFF->0000. LFSR right shift, new MSB = chl[5]^chl[3]^chl[2]^chl[0] (0001->8000->4000...). Steps only on a CAPT exit (accept or timeout); otherwise held.
- States: IDLE, SETTLE, MEAS, CAPT, OUT.
- IDLE: en=1 -> SETTLE next cycle.
- SETTLE: ro_en=0 for exactly SETTLE_CYC cycles -> MEAS.
- MEAS: ro_en=1 for exactly MEAS_CYC cycles -> CAPT. ro_en is registered and aligned to state.
- CAPT: ro_en=0. resp_vld=1 -> word<={word[W-2:0],resp_bit} (first bit lands in MSB), count++, step challenge. If count reaches W -> OUT, else -> SETTLE. No resp_vld within TMO_CYC cycles -> set tmo_err, discard bit, step challenge, -> SETTLE.
- resp_vld outside CAPT is ignored.
- OUT: out_valid=1 with out_data stable until out_ready=1. On the handshake cycle: out_valid<=0, count<=0, next state SETTLE if en else IDLE. out_ready with out_valid=0 has no effect.
- en=0 in SETTLE/MEAS/CAPT: next cycle IDLE, ro_en=0, partial word and count cleared, challenge kept.
- en=0 in OUT: word still held until accepted, then IDLE.
- clr_err and a timeout in the same cycle: set wins.
- Reset mid-operation: immediate return to reset values; any pending word is lost.
- Throughput: W*(SETTLE_CYC+MEAS_CYC+1+resp latency) cycles per word, plus backpressure.

Decomposition:
- Shared package: state encoding constants (IDLE..OUT), CG type constants (CG_CNT=1, CG_LFSR=2), challenge reset values, LFSR tap mask 16'h002D.
- One sub-module: roc_chl_step, a 16-bit stepped challenge generator with a step enable and a CG_TYPE generate selecting counter or LFSR.
- Window/timeout counter and FSM stay in roc_seq.

Test Plan:
- Counter mode, SETTLE_CYC=2, MEAS_CYC=4, resp_vld one cycle after CAPT entry -> ro_en high exactly 4 cycles per bit. cnf2/cnf1 run 00/00, 00/01, 00/02...
- W=8, resp bits 1,0,1,1,0,0,1,0, out_ready=1 -> one word out_data=8'hB2, out_valid high 1 cycle, count restarts.
- out_ready=0 for 20 cycles after out_valid -> out_data held 8'hB2, ro_en stays 0, no challenge step; handshake then resumes SETTLE.
- No resp_vld, TMO_CYC=8 -> tmo_err set 8 cycles after CAPT entry, challenge steps, word unchanged. clr_err pulse -> tmo_err=0.
- LFSR mode -> cnf2:cnf1 sequence 0001, 8000, 4000, 2000 over first four bits. en dropped mid-MEAS -> ro_en=0 and IDLE next cycle, challenge preserved.
- reset asserted mid-MEAS (asynchronously, between edges) -> ro_en, busy, out_valid drop at once; challenge returns to 0000 (counter).
